// File: rtl/ecliptic_fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ecliptic_fp_pkg
//  Purpose  : Shared definitions for the ecliptic FP-compare interface:
//             op-code encodings, the canonical quiet NaN and an op-legality
//             helper used by both the issuer and the comparator.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ecliptic_fp_pkg;

    localparam logic [2:0]  OP_LE         = 3'b000;
    localparam logic [2:0]  OP_LT         = 3'b001;
    localparam logic [2:0]  OP_EQ         = 3'b010;
    localparam logic [2:0]  OP_MIN        = 3'b100;
    localparam logic [2:0]  OP_MAX        = 3'b101;

    localparam logic [31:0] CANONICAL_NAN = 32'h7fc0_0000;

    // Encodings 011, 110 and 111 are reserved and must never reach the
    // comparator.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_LE, OP_LT, OP_EQ, OP_MIN, OP_MAX: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecliptic_compare_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : ecliptic_compare_issuer
//  Purpose  : Initiator side of the req/ack FP-compare interface. Takes
//             compare/min/max commands on a valid/ready channel, issues each
//             as a one-cycle req to the comparator, waits for ack (or times
//             out), and returns the result with its tag on a valid/ready
//             response channel. Maintains the sticky NV bit of fflags.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             cmd_valid/ready/op/src1/src2/tag - command channel
//             fpu_req/op/src1/src2           - request to comparator
//             fpu_res/invalid/ack            - comparator reply
//             rsp_valid/ready/data/tag/invalid/timeout - response channel
//             fflags_nv, fflags_clear        - sticky NV flag and its clear
//             busy                           - issuer not idle
//  Revision : 1.0 - initial release
// ============================================================================
module ecliptic_compare_issuer
    import ecliptic_fp_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_src1,
    input  logic [31:0]      cmd_src2,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             fpu_req,
    output logic [2:0]       fpu_op,
    output logic [31:0]      fpu_src1,
    output logic [31:0]      fpu_src2,
    input  logic [31:0]      fpu_res,
    input  logic             fpu_invalid,
    input  logic             fpu_ack,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_invalid,
    output logic             rsp_timeout,
    output logic             fflags_nv,
    input  logic             fflags_clear,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_fpu_op;
    logic [31:0]        r_fpu_src1;
    logic [31:0]        r_fpu_src2;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_invalid;
    logic               r_rsp_timeout;
    logic               r_nv;

    logic               w_accept;
    logic               w_legal;
    logic               w_ack;
    logic               w_expire;

    assign w_accept = cmd_valid & cmd_ready;
    assign w_legal  = op_is_legal(cmd_op);
    // Ack is only meaningful while waiting; anywhere else it is stray.
    assign w_ack    = (r_state == ST_WAIT) & fpu_ack;
    assign w_expire = (r_state == ST_WAIT) & ~fpu_ack & (r_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_legal ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_ack || w_expire) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_fpu_op      <= '0;
            r_fpu_src1    <= '0;
            r_fpu_src2    <= '0;
            r_tag         <= '0;
            r_rsp_data    <= '0;
            r_rsp_invalid <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tag <= cmd_tag;
                        if (w_legal) begin
                            r_fpu_op   <= cmd_op;
                            r_fpu_src1 <= cmd_src1;
                            r_fpu_src2 <= cmd_src2;
                        end else begin
                            // Reserved op: answer immediately with a null
                            // result and leave the comparator operands alone.
                            r_rsp_data    <= '0;
                            r_rsp_invalid <= 1'b0;
                            r_rsp_timeout <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    if (fpu_ack) begin
                        r_rsp_data    <= fpu_res;
                        r_rsp_invalid <= fpu_invalid;
                        r_rsp_timeout <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_data    <= '0;
                        r_rsp_invalid <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // RESP: response fields stay frozen until handshake.
                end
            endcase
        end
    end

    // Sticky NV: a new invalid ack takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nv <= 1'b0;
        end else if (w_ack && fpu_invalid) begin
            r_nv <= 1'b1;
        end else if (fflags_clear) begin
            r_nv <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready   = (r_state == ST_IDLE) & ~rst;
    assign fpu_req     = (r_state == ST_REQ);
    assign fpu_op      = r_fpu_op;
    assign fpu_src1    = r_fpu_src1;
    assign fpu_src2    = r_fpu_src2;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_tag     = r_tag;
    assign rsp_invalid = r_rsp_invalid;
    assign rsp_timeout = r_rsp_timeout;
    assign fflags_nv   = r_nv;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ecliptic_compare_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ecliptic_compare_issuer
//  Purpose  : Self-checking bench for ecliptic_compare_issuer. A behavioural
//             IEEE-754 comparator model answers requests; a transaction
//             timeline model gives the expected outputs for every cycle.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ecliptic_compare_issuer;

    localparam int TAG_W      = 5;
    localparam int TB_TIMEOUT = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_src1;
    logic [31:0]      cmd_src2;
    logic [TAG_W-1:0] cmd_tag;
    logic             fpu_req;
    logic [2:0]       fpu_op;
    logic [31:0]      fpu_src1;
    logic [31:0]      fpu_src2;
    logic [31:0]      fpu_res;
    logic             fpu_invalid;
    logic             fpu_ack;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_invalid;
    logic             rsp_timeout;
    logic             fflags_nv;
    logic             fflags_clear;
    logic             busy;

    ecliptic_compare_issuer #(
        .TAG_W   (TAG_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_src1     (cmd_src1),
        .cmd_src2     (cmd_src2),
        .cmd_tag      (cmd_tag),
        .fpu_req      (fpu_req),
        .fpu_op       (fpu_op),
        .fpu_src1     (fpu_src1),
        .fpu_src2     (fpu_src2),
        .fpu_res      (fpu_res),
        .fpu_invalid  (fpu_invalid),
        .fpu_ack      (fpu_ack),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_invalid  (rsp_invalid),
        .rsp_timeout  (rsp_timeout),
        .fflags_nv    (fflags_nv),
        .fflags_clear (fflags_clear),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Expected per-cycle values, written by the driver shortly after each
    // rising edge and compared on the falling edge.
    logic             chk_en;
    logic             e_cmd_ready, e_busy, e_req, e_rsp_valid;
    logic [31:0]      e_data;
    logic [TAG_W-1:0] e_tag;
    logic             e_inv, e_to;
    logic [2:0]       m_fpu_op;
    logic [31:0]      m_fpu_src1, m_fpu_src2;
    logic             m_set;
    logic             m_nv;

    logic [31:0]      last_data;
    logic [TAG_W-1:0] last_tag;
    logic             last_inv, last_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sticky-flag reference: an accepted invalid ack sets, clear clears, set wins.
    always @(posedge clk) begin
        if (rst)               m_nv <= 1'b0;
        else if (m_set)        m_nv <= 1'b1;
        else if (fflags_clear) m_nv <= 1'b0;
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("fpu_req",   32'(fpu_req),   32'(e_req));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            chk("fflags_nv", 32'(fflags_nv), 32'(m_nv));
            chk("fpu_op",    32'(fpu_op),    32'(m_fpu_op));
            chk("fpu_src1",  fpu_src1,       m_fpu_src1);
            chk("fpu_src2",  fpu_src2,       m_fpu_src2);
            if (e_rsp_valid) begin
                chk("rsp_data",    rsp_data,           e_data);
                chk("rsp_tag",     32'(rsp_tag),       32'(e_tag));
                chk("rsp_invalid", 32'(rsp_invalid),   32'(e_inv));
                chk("rsp_timeout", 32'(rsp_timeout),   32'(e_to));
            end
            if (rsp_valid && rsp_ready) begin
                last_data = rsp_data;
                last_tag  = rsp_tag;
                last_inv  = rsp_invalid;
                last_to   = rsp_timeout;
            end
        end
    end

    // ------------------------------------------------------------------
    // IEEE-754 single comparator model (RISC-V semantics)
    // ------------------------------------------------------------------
    function automatic bit f_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit f_snan(input logic [31:0] x);
        return f_nan(x) && !x[22];
    endfunction

    function automatic bit f_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    function automatic bit f_lt(input logic [31:0] a, input logic [31:0] b);
        if (f_zero(a) && f_zero(b)) return 1'b0;
        if (a[31] != b[31])         return a[31];
        if (!a[31])                 return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic bit f_eq(input logic [31:0] a, input logic [31:0] b);
        return (a == b) || (f_zero(a) && f_zero(b));
    endfunction

    task automatic cmp_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic inv);
        bit anynan, anysnan;
        anynan  = f_nan(a) || f_nan(b);
        anysnan = f_snan(a) || f_snan(b);
        res = 32'd0;
        inv = 1'b0;
        case (op)
            3'b000: begin inv = anynan;  res = (!anynan && (f_lt(a, b) || f_eq(a, b))) ? 32'd1 : 32'd0; end
            3'b001: begin inv = anynan;  res = (!anynan && f_lt(a, b)) ? 32'd1 : 32'd0; end
            3'b010: begin inv = anysnan; res = (!anynan && f_eq(a, b)) ? 32'd1 : 32'd0; end
            3'b100, 3'b101: begin
                inv = anysnan;
                if (f_nan(a) && f_nan(b))       res = 32'h7fc0_0000;
                else if (f_nan(a))              res = b;
                else if (f_nan(b))              res = a;
                else if (f_zero(a) && f_zero(b)) begin
                    if (op == 3'b100) res = (a[31] | b[31]) ? 32'h8000_0000 : 32'd0;
                    else              res = (a[31] & b[31]) ? 32'h8000_0000 : 32'd0;
                end
                else if (op == 3'b100)          res = f_lt(a, b) ? a : b;
                else                            res = f_lt(a, b) ? b : a;
            end
            default: begin res = 32'd0; inv = 1'b0; end
        endcase
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 10)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3f80_0000;
            3: return 32'hbf80_0000;
            4: return 32'h4000_0000;
            5: return 32'h7f80_0000;
            6: return 32'hff80_0000;
            7: return 32'h7fc0_0000;
            8: return 32'h7f80_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_idle_expect();
        cmd_valid    = 1'b0;
        fpu_ack      = 1'b0;
        fflags_clear = 1'b0;
        m_set        = 1'b0;
        e_cmd_ready  = 1'b1;
        e_busy       = 1'b0;
        e_req        = 1'b0;
        e_rsp_valid  = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // One command, timeline relative to the accept cycle (c = 0).
    //   d  : comparator ack arrives d cycles after req (0 = never)
    //   bp : cycles of rsp_ready low once the response is up
    // Called at rising edge + 1 with the DUT idle.
    // ------------------------------------------------------------------
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input int d, input int bp,
                           input int stray_pct, input int clr_pct, input bit clr_at_ack);
        bit          legal, acked;
        logic [31:0] res;
        logic        inv;
        int          r;
        legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                (op == 3'b100) || (op == 3'b101);
        cmp_model(op, a, b, res, inv);
        acked = legal && (d >= 1) && (d <= TB_TIMEOUT);
        r     = !legal ? 1 : (acked ? 2 + d : 2 + TB_TIMEOUT);
        for (int c = 0; c <= r + bp; c++) begin
            cmd_valid = (c == 0);
            if (c == 0) begin
                cmd_op = op; cmd_src1 = a; cmd_src2 = b; cmd_tag = tag;
            end else begin
                cmd_op = 3'($urandom); cmd_src1 = $urandom; cmd_src2 = $urandom;
                cmd_tag = TAG_W'($urandom);
            end
            m_set       = 1'b0;
            fpu_ack     = 1'b0;
            fpu_res     = $urandom;
            fpu_invalid = 1'($urandom);
            if (acked && c == 1 + d) begin
                fpu_ack = 1'b1; fpu_res = res; fpu_invalid = inv; m_set = inv;
            end else if ((c < 2 || c >= r) && (int'($urandom % 100) < stray_pct)) begin
                fpu_ack = 1'b1;
            end
            fflags_clear = (clr_at_ack && acked && c == 1 + d) ? 1'b1
                                                               : (int'($urandom % 100) < clr_pct);
            rsp_ready = (c >= r) ? (c == r + bp) : 1'($urandom);
            if (c == 1 && legal) begin
                m_fpu_op = op; m_fpu_src1 = a; m_fpu_src2 = b;
            end
            e_cmd_ready = (c == 0);
            e_busy      = (c != 0);
            e_req       = legal && (c == 1);
            e_rsp_valid = (c >= r);
            e_data      = acked ? res : 32'd0;
            e_inv       = acked ? inv : 1'b0;
            e_to        = legal && !acked;
            e_tag       = tag;
            @(posedge clk); #1;
        end
        set_idle_expect();
    endtask

    task automatic reset_in_wait();
        // c0: accept a legal LT
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_src1 = 32'h3f80_0000;
        cmd_src2 = 32'h4000_0000; cmd_tag = 5'd9; rsp_ready = 1'b1;
        @(posedge clk); #1;
        // c1: REQ
        cmd_valid = 1'b0;
        m_fpu_op = 3'b001; m_fpu_src1 = 32'h3f80_0000; m_fpu_src2 = 32'h4000_0000;
        e_cmd_ready = 1'b0; e_busy = 1'b1; e_req = 1'b1;
        @(posedge clk); #1;
        // c2: WAIT, no ack
        e_req = 1'b0;
        @(posedge clk); #1;
        // c3: WAIT with reset asserted
        rst = 1'b1;
        @(posedge clk); #1;
        // c4: reset released, late ack with invalid arrives
        rst = 1'b0;
        fpu_ack = 1'b1; fpu_invalid = 1'b1; fpu_res = 32'hdead_beef;
        m_fpu_op = 3'd0; m_fpu_src1 = 32'd0; m_fpu_src2 = 32'd0;
        e_cmd_ready = 1'b1; e_busy = 1'b0; e_req = 1'b0; e_rsp_valid = 1'b0;
        #1;
        chk("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        chk("rst_fflags_nv",   32'(fflags_nv),   32'd0);
        chk("rst_rsp_data",    rsp_data,         32'd0);
        chk("rst_rsp_tag",     32'(rsp_tag),     32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_fpu_src1",    fpu_src1,         32'd0);
        @(posedge clk); #1;
        // c5: the late ack must not have been taken
        fpu_ack = 1'b0;
        chk("rst_late_ack_valid", 32'(rsp_valid), 32'd0);
        chk("rst_late_ack_nv",    32'(fflags_nv), 32'd0);
        chk("rst_late_ack_busy",  32'(busy),      32'd0);
        set_idle_expect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; chk_en = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_tag = '0;
        fpu_res = '0; fpu_invalid = 1'b0; fpu_ack = 1'b0;
        rsp_ready = 1'b0; fflags_clear = 1'b0;
        m_set = 1'b0; m_fpu_op = '0; m_fpu_src1 = '0; m_fpu_src2 = '0;
        e_data = '0; e_tag = '0; e_inv = 1'b0; e_to = 1'b0;
        last_data = '0; last_tag = '0; last_inv = 1'b0; last_to = 1'b0;
        set_idle_expect();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_fpu_req",   32'(fpu_req),   32'd0);

        // LT 1.0 < 2.0
        run_cmd(3'b001, 32'h3f80_0000, 32'h4000_0000, 5'd7, 1, 0, 0, 0, 1'b0);
        chk("lt_data", last_data, 32'd1);
        chk("lt_tag",  32'(last_tag), 32'd7);
        chk("lt_inv",  32'(last_inv), 32'd0);

        // MIN with a signalling NaN
        run_cmd(3'b100, 32'h7f80_0001, 32'h3f80_0000, 5'd1, 1, 0, 0, 0, 1'b0);
        chk("min_snan_data", last_data, 32'h3f80_0000);
        chk("min_snan_inv",  32'(last_inv), 32'd1);
        chk("min_snan_nv",   32'(fflags_nv), 32'd1);

        // Clear coinciding with another NV ack: set wins
        run_cmd(3'b000, 32'h7fc0_0000, 32'h3f80_0000, 5'd2, 2, 0, 0, 0, 1'b1);
        chk("set_wins_nv", 32'(fflags_nv), 32'd1);
        fflags_clear = 1'b1;
        @(posedge clk); #1;
        fflags_clear = 1'b0;
        chk("clear_nv", 32'(fflags_nv), 32'd0);

        // EQ +0 vs -0 under backpressure
        run_cmd(3'b010, 32'h0000_0000, 32'h8000_0000, 5'd4, 1, 5, 0, 0, 1'b0);
        chk("eq_zero_data", last_data, 32'd1);

        // Timeout with stray acks while the response waits
        run_cmd(3'b001, 32'h3f80_0000, 32'h4000_0000, 5'd5, 0, 3, 100, 0, 1'b0);
        chk("timeout_flag", 32'(last_to), 32'd1);
        chk("timeout_data", last_data, 32'd0);

        // Ack in the last WAIT cycle is still taken; one later is not
        run_cmd(3'b101, 32'h3f80_0000, 32'h4000_0000, 5'd6, TB_TIMEOUT, 0, 0, 0, 1'b0);
        chk("late_ack_flag", 32'(last_to), 32'd0);
        chk("late_ack_data", last_data, 32'h4000_0000);
        run_cmd(3'b101, 32'h3f80_0000, 32'h4000_0000, 5'd6, TB_TIMEOUT + 1, 0, 0, 0, 1'b0);
        chk("too_late_flag", 32'(last_to), 32'd1);

        // Reserved op
        run_cmd(3'b011, 32'h1234_5678, 32'h9abc_def0, 5'd3, 1, 0, 50, 0, 1'b0);
        chk("illegal_data", last_data, 32'd0);
        chk("illegal_tag",  32'(last_tag), 32'd3);
        chk("illegal_inv",  32'(last_inv), 32'd0);

        reset_in_wait();

        for (int i = 0; i < 80; i++) begin
            run_cmd(3'($urandom), pick_operand(), pick_operand(), TAG_W'($urandom),
                    $urandom_range(0, TB_TIMEOUT + 2), $urandom_range(0, 3),
                    30, 20, 1'($urandom));
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecliptic_compare_issuer.md
Name: ecliptic_compare_issuer

Overview:
Initiator side of the req/ack FP-compare interface. Accepts compare/min/max commands from the FP execute stage over a valid/ready channel and issues each one as a single-cycle req to ecliptic_comparison. It waits for ack, or gives up on timeout. It returns the result with its destination tag on a valid/ready response channel, and keeps the sticky NV (invalid) bit of fflags.

Parameters:
TAG_W, 5, width of the destination-register tag carried with each command
TIMEOUT, 15, cycles spent in WAIT without ack before the command is aborted (must be >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  issuer can accept a command
cmd_op  in  3  000 LE, 001 LT, 010 EQ, 100 MIN, 101 MAX
cmd_src1  in  32  operand 1 (IEEE-754 single)
cmd_src2  in  32  operand 2
cmd_tag  in  TAG_W  destination tag
fpu_req  out  1  request to comparator
fpu_op  out  3  op to comparator
fpu_src1  out  32  operand 1 to comparator
fpu_src2  out  32  operand 2 to comparator
fpu_res  in  32  comparator result
fpu_invalid  in  1  comparator invalid flag
fpu_ack  in  1  comparator acknowledge
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  result
rsp_tag  out  TAG_W  tag of the command
rsp_invalid  out  1  NV raised by this command
rsp_timeout  out  1  command aborted, no ack
fflags_nv  out  1  sticky NV flag
fflags_clear  in  1  clears fflags_nv (CSR write)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0: fpu_req, fpu_op, fpu_src*, rsp_*, fflags_nv, busy.
  - Timeout counter cleared.
  - An in-flight command is dropped silently.
  - An ack arriving after reset is ignored.
- cmd_ready = (state==IDLE) & ~rst. A command is accepted on cmd_valid & cmd_ready.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On accept with a legal op: register op/src1/src2/tag onto fpu_* and the tag register, then go to REQ.
  - On accept with an illegal op (011, 110, 111): go directly to RESP with rsp_data=0, rsp_invalid=0, rsp_timeout=0. No req is issued.
- REQ:
  - fpu_req=1 for exactly this one cycle.
  - fpu_op/src are held stable until the next command.
  - Clear the counter and go to WAIT.
- WAIT (fpu_req=0):
  - On fpu_ack: capture rsp_data=fpu_res, rsp_invalid=fpu_invalid, rsp_timeout=0, then go to RESP.
  - Otherwise, increment the counter.
  - When the counter reaches TIMEOUT-1 with no ack: rsp_data=0, rsp_invalid=0, rsp_timeout=1, then go to RESP.
- fpu_ack is only sampled in WAIT. An ack in IDLE, REQ or RESP is ignored.
- RESP:
  - rsp_valid=1. rsp_data, rsp_tag, rsp_invalid and rsp_timeout are held stable while rsp_valid & ~rsp_ready.
  - On rsp_ready: go to IDLE and drop rsp_valid on the next cycle.
  - No combinational path from rsp_ready to cmd_ready. The next command is accepted one cycle after the handshake.
- Latency against a compliant comparator (ack one cycle after req):
  - cmd accepted at edge 0.
  - fpu_req high in cycle 1.
  - ack in cycle 2.
  - rsp_valid in cycle 3.
- Throughput: one command per 4 cycles when rsp_ready is held high.
- fflags_nv:
  - Set at the edge where an ack with fpu_invalid=1 is captured in WAIT.
  - Cleared by fflags_clear.
  - If set and clear coincide, set wins.
  - Unaffected by timeout and by illegal ops.
- busy = (state != IDLE).

Decomposition:
- Package ecliptic_fp_pkg, shared with ecliptic_comparison: op-code constants (OP_LE, OP_LT, OP_EQ, OP_MIN, OP_MAX), CANONICAL_NAN, and a function for op legality.
- The FSM state enum is local to this module.
- No sub-module; the timeout counter is inline, with width $clog2(TIMEOUT)+1.

Test Plan:
- LT: src1=3f800000 (1.0), src2=40000000 (2.0), tag=7, paired with a real ecliptic_comparison, rsp_ready=1 -> fpu_req pulses one cycle; rsp_valid in cycle 3; rsp_data=00000001, rsp_tag=7, rsp_invalid=0.
- MIN: src1=7f800001 (sNaN), src2=3f800000 -> rsp_data=3f800000, rsp_invalid=1, fflags_nv=1. Then fflags_clear=1 in the same cycle as another NV ack -> fflags_nv remains 1.
- Backpressure: EQ on 00000000 vs 80000000, rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with rsp_data=00000001 stable; cmd_ready=0 throughout; cmd_ready=1 one cycle after the handshake.
- Timeout: TIMEOUT=4, stub comparator never acks -> rsp_timeout=1, rsp_data=0 after 4 WAIT cycles. A stray ack injected while in RESP does not alter rsp_data.
- Illegal op 3'b011, tag=3 -> fpu_req never asserts; rsp_valid one cycle after accept; rsp_data=0, rsp_tag=3, rsp_invalid=0.
- rst=1 during WAIT, with ack arriving the next cycle -> all outputs 0, state IDLE, fflags_nv=0, no rsp_valid; cmd_ready=1 in the first cycle after rst deasserts.
